ex_muldiv_seq: RTL and testbench

EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

---
 rtl/ex_muldiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide sharing one 64-bit accumulator, with a 4-state IDLE/CALC/FIX/DONE controller.
//
// Handshake: start is sampled only in IDLE (with flush low); stall holds the
// pipeline from the accepting cycle through FIX; done pulses for one cycle in DONE
// and result stays valid until the next accepted operation completes.
module ex_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  state_t            state_q;
  logic [4:0]        cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   opb_q;     // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0]   hi_q;      // product high word / partial remainder
  logic [XLEN-1:0]   lo_q;      // product low word+multiplier / dividend+quotient
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  // Operand decode at issue
  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              is_div;
  logic              div_zero;
  logic              div_ovf;
  logic              fast_path;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    a_signed  = (md_op == OP_MULH) || (md_op == OP_MULHSU) ||
                (md_op == OP_DIV)  || (md_op == OP_REM);
    b_signed  = (md_op == OP_MULH) || (md_op == OP_DIV) || (md_op == OP_REM);
    a_neg     = a_signed && rs1_data[XLEN-1];
    b_neg     = b_signed && rs2_data[XLEN-1];
    a_mag     = a_neg ? (~rs1_data + 1'b1) : rs1_data;
    b_mag     = b_neg ? (~rs2_data + 1'b1) : rs2_data;
    is_div    = md_op[2];
    div_zero  = is_div && (rs2_data == '0);
    div_ovf   = is_div && !md_op[0] &&
                (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    fast_path = div_zero || div_ovf;
    // md_op[1] separates the remainder ops from the quotient ops
    if (div_zero) begin
      fast_res = md_op[1] ? rs1_data : '1;
    end else begin
      fast_res = md_op[1] ? '0 : rs1_data;
    end
  end

  // One radix-2 step of each algorithm
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_d;
  logic [XLEN-1:0]   mul_lo_d;
  logic [XLEN:0]     div_trial;
  logic              div_borrow;
  logic [XLEN-1:0]   div_hi_d;
  logic [XLEN-1:0]   div_lo_d;

  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_hi_d   = mul_sum[XLEN:1];
    mul_lo_d   = {mul_sum[0], lo_q[XLEN-1:1]};
    div_trial  = {hi_q, lo_q[XLEN-1]} - {1'b0, opb_q};
    div_borrow = div_trial[XLEN];
    div_hi_d   = div_borrow ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : div_trial[XLEN-1:0];
    div_lo_d   = {lo_q[XLEN-2:0], ~div_borrow};
  end

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_res_q ? (~prod + 1'b1) : prod;
    quot_s = neg_res_q ? (~lo_q + 1'b1) : lo_q;
    rem_s  = neg_rem_q ? (~hi_q + 1'b1) : hi_q;
    case (op_q)
      OP_MUL:         fix_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:     fix_res = quot_s;
      default:        fix_res = rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      // Abort wins over everything, including a same-cycle start
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q  <= md_op;
            cnt_q <= '0;
            if (fast_path) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              hi_q      <= '0;
              lo_q      <= is_div ? a_mag : b_mag;
              opb_q     <= is_div ? b_mag : a_mag;
              neg_res_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              state_q   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          hi_q  <= op_q[2] ? div_hi_d : mul_hi_d;
          lo_q  <= op_q[2] ? div_lo_d : mul_lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Reset low masks start so the pipeline is never held while in reset
  assign stall     = rst_n && (((state_q == S_IDLE) && start && !flush) ||
                               (state_q == S_CALC) || (state_q == S_FIX));
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for ex_muldiv_seq: directed RV32M corner cases plus random ops, checked
// every cycle against an arithmetic reference model and a latency scoreboard.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  ex_muldiv_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .md_op     (md_op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] model_res = '0;
  int          checks = 0;
  int          errors = 0;
  logic        is_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RV32M semantics in plain 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Compare process: every cycle, outputs vs. model state
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      is_d = (cyc == cyc_q[0]);
      chk("busy_active", {31'd0, busy}, 32'd1);
      chk("stall_active", {31'd0, stall}, {31'd0, !is_d});
      chk("done_timing", {31'd0, done}, {31'd0, is_d});
      if (is_d) begin
        chk("result", result, exp_q[0]);
        model_res = exp_q[0];
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end else begin
        chk("result_hold", result, model_res);
      end
    end else begin
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("done_idle", {31'd0, done}, 32'd0);
      chk("stall_idle", {31'd0, stall}, {31'd0, start && !flush && rst_n});
      chk("result_idle", result, model_res);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic begin_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs1_data = a; rs2_data = b;
  endtask

  // Called right after driving start: takes the capture edge and books the result
  task automatic capture(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    @(posedge clk); #1;
    exp_q.push_back(exp);
    cyc_q.push_back(cyc + (is_fast(op, a, b) ? 0 : 33));
    start = 1'b0;
    md_op = 3'($urandom_range(0, 7));
    rs1_data = $urandom;
    rs2_data = $urandom;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    @(posedge clk); #1;
    begin_op(op, a, b);
    capture(op, a, b, exp);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending ops expected 0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  task automatic issue_lit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lit);
    chk("model_pin", ref_md(op, a, b), lit);
    issue(op, a, b, lit);
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stall_masked", {31'd0, stall}, 32'd0);
    chk("rst_result", result, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed corner cases
    issue_lit(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    issue_lit(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue_lit(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    issue_lit(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    issue_lit(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    issue_lit(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    issue_lit(3'd5, 32'd100, 32'd4, 32'd25);
    issue_lit(3'd7, 32'd100, 32'd3, 32'd1);
    issue_lit(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    issue_lit(3'd6, 32'd5, 32'd0, 32'd5);
    issue_lit(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    issue_lit(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Flush at CALC step 10, then back-to-back MUL 3x4
    issue(3'd0, 32'd5, 32'd6, 32'd30);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    cyc_q.delete();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_result", result, model_res);
    chk("model_pin", ref_md(3'd0, 32'd3, 32'd4), 32'd12);
    begin_op(3'd0, 32'd3, 32'd4);
    capture(3'd0, 32'd3, 32'd4, 32'd12);
    wait_idle();

    // Flush beats a simultaneous start in IDLE
    @(posedge clk); #1;
    begin_op(3'd5, 32'd9, 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);

    // Start while busy is ignored: exactly one done for the original op
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, ref_md(3'd3, 32'hDEAD_BEEF, 32'h1234_5678));
    repeat (3) @(posedge clk);
    #1 begin_op(3'd4, 32'd77, 32'd0);
    repeat (5) @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (5) @(posedge clk);

    // Reset at CALC step 20 abandons the op
    issue(3'd5, 32'd1000, 32'd7, 32'd142);
    repeat (20) @(posedge clk);
    #1;
    exp_q.delete();
    cyc_q.delete();
    model_res = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue_lit(3'd7, 32'd100, 32'd7, 32'd2);

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = 32'd0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: begin r_a = $urandom_range(0, 20); r_b = $urandom_range(0, 20); end
        3: r_b = $urandom_range(1, 15);
        4: r_b = -($urandom_range(1, 15));
        default: ;
      endcase
      issue(r_op, r_a, r_b, ref_md(r_op, r_a, r_b));
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
